hex_scan_display: RTL and testbench

- Parametrised multiplexed 7-segment driver for N hexadecimal digits.
- Time-multiplexes one digit per refresh slot.
- Adds tear-free double-buffered data load, per-digit decimal points, per-digit enables, leading-zero blanking and PWM brightness control.
- Sits between the datapath result bus and the board anode/cathode pins.
- Replaces the fixed 4-digit display path.

---
 rtl/hex_disp_pkg.sv | 26 ++
 rtl/seg7_hex_lut.sv | 11 +
 rtl/hex_scan_display.sv | 136 +++++++++++++
 tb/tb_hex_scan_display.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared constants and helpers for the multiplexed hexadecimal 7-segment driver.
// Segment bits are active-high here; the top inverts them for the pins.
package hex_disp_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic ANODE_OFF = 1'b1;

  // Segment order is {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // A single-digit display still needs a one-bit index register.
  function automatic int idx_width(input int n_digits);
    return (n_digits <= 1) ? 1 : $clog2(n_digits);
  endfunction

  function automatic logic anode_bit(input int pos, input int sel, input logic lit);
    return (lit && (pos == sel)) ? ~ANODE_OFF : ANODE_OFF;
  endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_hex_lut
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/hex_scan_display.sv
// Multiplexed N-digit hex display driver: slot scan, frame-aligned double buffer,
// leading-zero blanking, per-digit enables and PWM dimming with registered pins.
module hex_scan_display
  import hex_disp_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DIM_BITS    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] data,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  blank_lz,
  input  logic [DIM_BITS-1:0]   brightness,
  output logic [N_DIGITS-1:0]   anode,
  output logic [7:0]            catode,
  output logic                  frame_done
);

  localparam int IDX_W  = idx_width(N_DIGITS);
  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [SLOT_W-1:0]     slot_cnt;
  logic [IDX_W-1:0]      idx;
  logic [DIM_BITS-1:0]   pwm_cnt;

  logic [4*N_DIGITS-1:0] pend_data;
  logic [N_DIGITS-1:0]   pend_dp;
  logic                  pend_valid;
  logic [4*N_DIGITS-1:0] act_data;
  logic [N_DIGITS-1:0]   act_dp;

  logic                  slot_end;
  logic                  frame_wrap;

  logic [N_DIGITS-1:0]   lz_blank;
  logic                  nonzero_above;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [6:0]            cur_seg;
  logic                  pwm_on;
  logic                  lit;
  logic [N_DIGITS-1:0]   anode_next;
  logic [7:0]            catode_next;

  assign slot_end   = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
      idx      <= '0;
      pwm_cnt  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + DIM_BITS'(1);
      if (slot_end) begin
        slot_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
    end
  end

  // Active only changes at the frame wrap, so a frame is never drawn from two values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
    end else if (load && frame_wrap) begin
      act_data   <= data;
      act_dp     <= dp;
      pend_valid <= 1'b0;
    end else begin
      if (frame_wrap && pend_valid) begin
        act_data   <= pend_data;
        act_dp     <= pend_dp;
        pend_valid <= 1'b0;
      end
      if (load) begin
        pend_data  <= data;
        pend_dp    <= dp;
        pend_valid <= 1'b1;
      end
    end
  end

  // Walk from the most significant digit down; a digit stays blank until something shows above or at it.
  always_comb begin
    nonzero_above = 1'b0;
    lz_blank      = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      nonzero_above = nonzero_above | (act_data[4*i +: 4] != 4'h0) | act_dp[i];
      lz_blank[i]   = (i != 0) && !nonzero_above;
    end
  end

  assign cur_nib = act_data[{idx, 2'b00} +: 4];
  assign cur_dp  = act_dp[idx];
  assign pwm_on  = (pwm_cnt <= brightness);
  assign lit     = digit_en[idx] && pwm_on && !(blank_lz && lz_blank[idx]);

  seg7_hex_lut u_lut (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_comb begin
    anode_next = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      anode_next[i] = anode_bit(i, int'(idx), lit);
    end
    catode_next = lit ? ~{cur_dp, cur_seg} : SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      anode      <= {N_DIGITS{ANODE_OFF}};
      catode     <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_next;
      catode     <= catode_next;
      frame_done <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display: a time-based reference model predicts the pins
// for every clock and a negedge monitor compares them against the DUT.
module tb_hex_scan_display;

  localparam int N = 4;
  localparam int R = 4;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data;
  logic        load;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic [1:0]  brightness;
  logic [3:0]  anode;
  logic [7:0]  catode;
  logic        frame_done;

  hex_scan_display #(
    .N_DIGITS    (N),
    .REFRESH_DIV (R),
    .DIM_BITS    (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .load       (load),
    .dp         (dp),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .anode      (anode),
    .catode     (catode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] anode;
    logic [7:0] catode;
    logic       frame_done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] font [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int          t;
  logic [15:0] m_act_data, m_pend_data;
  logic [3:0]  m_act_dp, m_pend_dp;
  bit          m_pend_valid;
  int          m_digit;
  bit          m_boundary, m_pwm_on, m_blanked, m_lit;
  logic [3:0]  m_nib;
  exp_t        m_e;
  exp_t        mon_e;

  // Reference model: position in the scan is derived purely from cycles elapsed since reset.
  always @(posedge clk) begin
    if (reset) begin
      m_e          = '{anode: 4'hF, catode: 8'hFF, frame_done: 1'b0};
      t            = 0;
      m_act_data   = '0;
      m_act_dp     = '0;
      m_pend_data  = '0;
      m_pend_dp    = '0;
      m_pend_valid = 1'b0;
    end else begin
      m_digit    = (t / R) % N;
      m_boundary = (t % (R * N)) == (R * N - 1);
      m_pwm_on   = (t % (1 << D)) <= int'(brightness);
      m_blanked  = blank_lz && (m_digit > 0) &&
                   ((m_act_data >> (4 * m_digit)) == 16'h0) &&
                   ((m_act_dp >> m_digit) == 4'h0);
      m_lit      = digit_en[m_digit] && m_pwm_on && !m_blanked;
      m_nib      = 4'((m_act_data >> (4 * m_digit)) & 16'hF);
      m_e.anode      = m_lit ? ~(4'b0001 << m_digit) : 4'hF;
      m_e.catode     = m_lit ? ~{m_act_dp[m_digit], font[m_nib]} : 8'hFF;
      m_e.frame_done = m_boundary;
      if (load && m_boundary) begin
        m_act_data   = data;
        m_act_dp     = dp;
        m_pend_valid = 1'b0;
      end else begin
        if (m_boundary && m_pend_valid) begin
          m_act_data   = m_pend_data;
          m_act_dp     = m_pend_dp;
          m_pend_valid = 1'b0;
        end
        if (load) begin
          m_pend_data  = data;
          m_pend_dp    = dp;
          m_pend_valid = 1'b1;
        end
      end
      t++;
    end
    exp_q.push_back(m_e);
  end

  task automatic checkOutput(input exp_t e);
    checks++;
    if ({anode, catode, frame_done} !== e) begin
      errors++;
      $display("[TB] FAIL pins @%0t: got anode=%b catode=%h frame_done=%b, want anode=%b catode=%h frame_done=%b",
               $time, anode, catode, frame_done, e.anode, e.catode, e.frame_done);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput(mon_e);
    end
  end

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    data = d;
    dp   = p;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    load       = 1'b0;
    data       = '0;
    dp         = '0;
    digit_en   = 4'hF;
    blank_lz   = 1'b0;
    brightness = 2'd3;
    idle(3);
    reset = 1'b0;

    $display("[TB] directed: basic scan of 12AF");
    applyStimulus(16'h12AF, 4'h0);
    idle(36);

    $display("[TB] directed: back-to-back loads before a boundary");
    idle(5);
    applyStimulus(16'h0000, 4'h0);
    idle(3);
    applyStimulus(16'h0040, 4'h0);
    idle(40);

    $display("[TB] directed: leading-zero blanking and dp");
    blank_lz = 1'b1;
    idle(20);
    applyStimulus(16'h0040, 4'b1000);
    idle(40);

    $display("[TB] directed: brightness levels");
    brightness = 2'd0;
    idle(32);
    brightness = 2'd2;
    idle(32);
    brightness = 2'd3;

    $display("[TB] directed: digit enables");
    digit_en = 4'b1010;
    idle(32);
    digit_en = 4'hF;

    $display("[TB] directed: reset mid-slot at digit 2");
    idle(16 - (t % 16) + 9);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(24);

    $display("[TB] random phase");
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      load  = ($urandom_range(0, 11) == 0);
      data  = 16'($urandom >> (4 * $urandom_range(0, 4) + 16));
      dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      reset = ($urandom_range(0, 400) == 0);
      if ($urandom_range(0, 40) == 0) brightness = 2'($urandom);
      if ($urandom_range(0, 60) == 0) digit_en = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 50) == 0) blank_lz = ~blank_lz;
    end
    @(negedge clk);
    load  = 1'b0;
    reset = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
